// File: rtl/interp_upscaler_pkg.sv
// Shared constants and channel arithmetic for the 2x interpolating upscaler.
package interp_upscaler_pkg;

  localparam logic MODE_NEAREST  = 1'b0;
  localparam logic MODE_BILINEAR = 1'b1;

  // Widest colour channel the average helper supports.
  localparam int MAX_CH_W = 16;

  // Rounded (half-up) mean of two channel values. The sum is formed one bit
  // wider than the operands, so it cannot overflow. Callers zero-extend
  // narrower channels into the operands. They then truncate the result back
  // to their own channel width; the mean of two CH_W-bit values always fits.
  function automatic logic [MAX_CH_W-1:0] ch_avg(input logic [MAX_CH_W-1:0] a,
                                                 input logic [MAX_CH_W-1:0] b);
    logic [MAX_CH_W:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {{MAX_CH_W{1'b0}}, 1'b1};
    return sum[MAX_CH_W:1];
  endfunction

endpackage

// File: rtl/interp_upscaler_if.sv
// Source frame-buffer read port used by the upscaler.
// Read semantics: src_en/src_addr are driven combinationally by the reader.
// The memory returns src_data for that address exactly one clk later.
// There is no back-pressure: every strobed address is answered.
interface interp_upscaler_if #(
  parameter int ADDR_W = 17,
  parameter int PW     = 12
);
  logic              src_en;
  logic [ADDR_W-1:0] src_addr;
  logic [PW-1:0]     src_data;

  modport master (output src_en, output src_addr, input src_data);
  modport slave  (input src_en, input src_addr, output src_data);
endinterface

// File: rtl/interp_linebuf.sv
// One-line pixel store: a write port and a registered read port, no reset.
// This shape maps onto a simple dual-port block RAM.
module interp_linebuf #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 12,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             re,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write side: store the pixel when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Read side: the data is registered, so it arrives on the clk after the address.
  always_ff @(posedge clk) begin
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/interp_upscaler.sv
// 2x upscaler: nearest-neighbour or bilinear interpolation driven from VGA timing.
// Two-clk pipeline: source fetch, then horizontal/vertical blend, then output register.
module interp_upscaler
  import interp_upscaler_pkg::*;
#(
  parameter int SRC_W  = 320,
  parameter int SRC_H  = 240,
  parameter int CH_W   = 4,
  parameter int NCH    = 3,
  parameter int ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            x_pixel,
  input  logic [9:0]            y_pixel,
  input  logic                  mode,
  interp_upscaler_if.master     src,
  output logic [NCH*CH_W-1:0]   pix_out,
  output logic                  de_out
);

  localparam int PW       = NCH * CH_W;
  localparam int LB_DEPTH = 2 * SRC_W;
  localparam int LB_AW    = $clog2(LB_DEPTH);

  // Average each channel of two pixels independently.
  function automatic logic [PW-1:0] pix_avg(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) begin
      r[i*CH_W +: CH_W] = CH_W'(ch_avg(MAX_CH_W'(a[i*CH_W +: CH_W]),
                                       MAX_CH_W'(b[i*CH_W +: CH_W])));
    end
    return r;
  endfunction

  logic             active;
  logic             origin;
  logic             cur_mode;
  logic             mode_q;
  logic [9:0]       col;
  logic [9:0]       row;

  logic             active_d1;
  logic             mode_d1;
  logic             y_odd_d1;
  logic [LB_AW-1:0] x_d1;
  logic [PW-1:0]    prev_pix;

  logic [PW-1:0]    h_pix;
  logic [PW-1:0]    pix_next;
  logic [PW-1:0]    lb_rdata;
  logic             lb_we;

  // Pick the source pixel for the current coordinate and drive the read port.
  // At the frame origin the incoming mode is used directly, so the first
  // pixel of a frame already follows the newly latched mode.
  always_comb begin
    active   = (32'(x_pixel) < 2 * SRC_W) && (32'(y_pixel) < 2 * SRC_H);
    origin   = (x_pixel == '0) && (y_pixel == '0);
    cur_mode = origin ? mode : mode_q;
    if (cur_mode == MODE_BILINEAR) begin
      col = 10'(({1'b0, x_pixel} + 11'd1) >> 1);
      row = 10'(({1'b0, y_pixel} + 11'd1) >> 1);
      if (32'(col) > SRC_W - 1) col = 10'(SRC_W - 1);
      if (32'(row) > SRC_H - 1) row = 10'(SRC_H - 1);
    end else begin
      col = {1'b0, x_pixel[9:1]};
      row = {1'b0, y_pixel[9:1]};
    end
    src.src_en   = active;
    src.src_addr = active ? (ADDR_W'(row) * ADDR_W'(SRC_W) + ADDR_W'(col)) : '0;
  end

  // Latch the interpolation mode once per frame, at the origin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       mode_q <= MODE_NEAREST;
    else if (origin) mode_q <= mode;
  end

  // First pipeline stage: carry the coordinate context alongside the fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_d1 <= 1'b0;
      mode_d1   <= MODE_NEAREST;
      y_odd_d1  <= 1'b0;
      x_d1      <= '0;
      prev_pix  <= '0;
    end else begin
      active_d1 <= active;
      mode_d1   <= cur_mode;
      y_odd_d1  <= y_pixel[0];
      x_d1      <= LB_AW'(x_pixel);
      prev_pix  <= src.src_data;
    end
  end

  // Blend stage. Odd columns mix with the previous fetch; even columns
  // (including x = 0) never look at prev_pix, so no blend carries across
  // lines. Odd lines mix with the stored even line.
  always_comb begin
    h_pix = src.src_data;
    if (x_d1[0]) h_pix = pix_avg(prev_pix, src.src_data);
    if (mode_d1 == MODE_NEAREST) pix_next = src.src_data;
    else if (y_odd_d1)           pix_next = pix_avg(lb_rdata, h_pix);
    else                         pix_next = h_pix;
    lb_we = active_d1 && (mode_d1 == MODE_BILINEAR) && !y_odd_d1;
  end

  // Output register; blanking forces a zero pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_out <= '0;
      de_out  <= 1'b0;
    end else begin
      pix_out <= active_d1 ? pix_next : '0;
      de_out  <= active_d1;
    end
  end

  // Both ports are indexed by destination column x. The read is issued at
  // fetch time, so its data lines up with the blend stage one clk later.
  interp_linebuf #(
    .DEPTH (LB_DEPTH),
    .WIDTH (PW),
    .AW    (LB_AW)
  ) u_linebuf (
    .clk     (clk),
    .we      (lb_we),
    .wr_addr (x_d1),
    .wr_data (h_pix),
    .re      (active),
    .rd_addr (LB_AW'(x_pixel)),
    .rd_data (lb_rdata)
  );

endmodule

// File: tb/tb_interp_upscaler.sv
// Directed bench for interp_upscaler: nearest-mode vector table plus
// hand-built bilinear, edge, mode-switch and reset sequences.
`timescale 1ns/1ps
module tb_interp_upscaler;

  localparam int SRC_W  = 320;
  localparam int SRC_H  = 240;
  localparam int CH_W   = 4;
  localparam int NCH    = 3;
  localparam int ADDR_W = 17;
  localparam int PW     = NCH * CH_W;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [9:0]    x_pixel;
  logic [9:0]    y_pixel;
  logic          mode;
  logic [PW-1:0] pix_out;
  logic          de_out;

  always #20 clk = ~clk;

  interp_upscaler_if #(.ADDR_W(ADDR_W), .PW(PW)) sif ();

  interp_upscaler #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .CH_W(CH_W), .NCH(NCH), .ADDR_W(ADDR_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .x_pixel (x_pixel),
    .y_pixel (y_pixel),
    .mode    (mode),
    .src     (sif),
    .pix_out (pix_out),
    .de_out  (de_out)
  );

  // Source frame memory model: answers one clk after the address.
  logic [PW-1:0] mem [SRC_W*SRC_H];
  always @(posedge clk) begin
    if (sif.src_addr < ADDR_W'(SRC_W * SRC_H)) sif.src_data <= mem[sif.src_addr];
    else                                       sif.src_data <= '0;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [PW+1:0] exp_q[$];   // {chk, de, pix} per driven cycle
  string         name_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clk: drive a coordinate, queue its expected output (due two clks
  // later), and compare the output that is due in this clk.
  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic m,
                      input logic r, input logic chk, input logic de,
                      input logic [PW-1:0] pix, input string name);
    logic [PW+1:0] e;
    string nm;
    @(posedge clk);
    #1;
    reset   = r;
    x_pixel = x;
    y_pixel = y;
    mode    = m;
    exp_q.push_back({chk, de, pix});
    name_q.push_back(name);
    @(negedge clk);
    if (exp_q.size() > 2) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (reset) begin
        check({nm, " de(rst)"}, 32'(de_out), 32'd0);
        check({nm, " pix(rst)"}, 32'(pix_out), 32'd0);
      end else if (e[PW+1]) begin
        check({nm, " de"}, 32'(de_out), 32'(e[PW]));
        check({nm, " pix"}, 32'(pix_out), 32'(e[PW-1:0]));
      end
    end
  endtask

  task automatic idle(input logic [9:0] y, input logic m);
    step(10'd700, y, m, 1'b0, 1'b1, 1'b0, '0, "blank");
  endtask

  task automatic ramp_fill();
    for (int r = 0; r < SRC_H; r++)
      for (int c = 0; c < SRC_W; c++)
        mem[r*SRC_W + c] = {4'(r), 4'(c), 4'h0};
  endtask

  // ---------------- vector table (nearest mode, ramp source) ----------------
  typedef struct {
    logic [9:0]        x;
    logic [9:0]        y;
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic              de;
    logic [PW-1:0]     pix;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{10'd0,   10'd0,   1'b1, 17'd0,     1'b1, 12'h000};
    vecs[1]  = '{10'd5,   10'd7,   1'b1, 17'd962,   1'b1, 12'h320};
    vecs[2]  = '{10'd3,   10'd2,   1'b1, 17'd321,   1'b1, 12'h110};
    vecs[3]  = '{10'd200, 10'd100, 1'b1, 17'd16100, 1'b1, 12'h240};
    vecs[4]  = '{10'd33,  10'd17,  1'b1, 17'd2576,  1'b1, 12'h800};
    vecs[5]  = '{10'd639, 10'd0,   1'b1, 17'd319,   1'b1, 12'h0F0};
    vecs[6]  = '{10'd0,   10'd479, 1'b1, 17'd76480, 1'b1, 12'hF00};
    vecs[7]  = '{10'd639, 10'd479, 1'b1, 17'd76799, 1'b1, 12'hFF0};
    vecs[8]  = '{10'd700, 10'd10,  1'b0, 17'd0,     1'b0, 12'h000};
    vecs[9]  = '{10'd640, 10'd0,   1'b0, 17'd0,     1'b0, 12'h000};
    vecs[10] = '{10'd100, 10'd480, 1'b0, 17'd0,     1'b0, 12'h000};
    vecs[11] = '{10'd639, 10'd478, 1'b1, 17'd76799, 1'b1, 12'hFF0};

    reset   = 1'b1;
    x_pixel = 10'd700;
    y_pixel = 10'd0;
    mode    = 1'b0;
    ramp_fill();
    repeat (3) @(negedge clk);
    check("reset de", 32'(de_out), 32'd0);
    check("reset pix", 32'(pix_out), 32'd0);
    check("reset src_en", 32'(sif.src_en), 32'd0);
    idle(10'd0, 1'b0);
    idle(10'd0, 1'b0);

    // Nearest-neighbour table, one coordinate per clk.
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].x, vecs[i].y, 1'b0, 1'b0, 1'b1, vecs[i].de, vecs[i].pix,
           $sformatf("vec%0d", i));
      check($sformatf("vec%0d en", i), 32'(sif.src_en), 32'(vecs[i].en));
      check($sformatf("vec%0d addr", i), 32'(sif.src_addr), 32'(vecs[i].addr));
    end
    idle(10'd0, 1'b0);
    idle(10'd0, 1'b0);

    // Bilinear horizontal blend with round-half-up.
    mem[0] = 12'h000;
    mem[1] = 12'hFFF;
    step(10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000, "bh x0");
    step(10'd1, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h888, "bh x1");
    check("bh x1 addr", 32'(sif.src_addr), 32'd1);
    idle(10'd0, 1'b1);
    idle(10'd0, 1'b1);

    // Bilinear vertical blend against the line buffer.
    mem[0]   = 12'h222;
    mem[320] = 12'h445;
    step(10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h222, "bv y0");
    idle(10'd0, 1'b1);
    idle(10'd0, 1'b1);
    step(10'd0, 10'd1, 1'b1, 1'b0, 1'b1, 1'b1, 12'h334, "bv y1");
    check("bv y1 addr", 32'(sif.src_addr), 32'd320);
    idle(10'd0, 1'b1);
    idle(10'd0, 1'b1);

    // Right and bottom edges in bilinear mode.
    mem[0]   = 12'h000;
    mem[1]   = 12'h010;
    mem[320] = 12'h100;
    step(10'd0,   10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000, "edge origin");
    step(10'd638, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h0F0, "edge x638");
    check("edge x638 addr", 32'(sif.src_addr), 32'd319);
    step(10'd639, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h0F0, "edge x639");
    check("edge x639 addr", 32'(sif.src_addr), 32'd319);
    idle(10'd0, 1'b1);
    idle(10'd0, 1'b1);
    step(10'd0, 10'd478, 1'b1, 1'b0, 1'b1, 1'b1, 12'hF00, "edge y478");
    check("edge y478 addr", 32'(sif.src_addr), 32'd76480);
    idle(10'd0, 1'b1);
    idle(10'd0, 1'b1);
    step(10'd0, 10'd479, 1'b1, 1'b0, 1'b1, 1'b1, 12'hF00, "edge y479");
    check("edge y479 addr", 32'(sif.src_addr), 32'd76480);
    idle(10'd0, 1'b1);
    idle(10'd0, 1'b1);

    // Mode change mid-frame only takes effect at the next origin.
    step(10'd0,   10'd0,  1'b0, 1'b0, 1'b1, 1'b1, 12'h000, "mt origin0");
    step(10'd100, 10'd50, 1'b1, 1'b0, 1'b1, 1'b1, 12'h920, "mt x100");
    check("mt x100 addr", 32'(sif.src_addr), 32'd8050);
    step(10'd101, 10'd50, 1'b1, 1'b0, 1'b1, 1'b1, 12'h920, "mt x101");
    check("mt x101 addr", 32'(sif.src_addr), 32'd8050);
    idle(10'd50, 1'b1);
    idle(10'd50, 1'b1);
    step(10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000, "mt origin1");
    step(10'd2, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h010, "mt x2");
    check("mt x2 addr", 32'(sif.src_addr), 32'd1);
    step(10'd3, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h020, "mt x3");
    check("mt x3 addr", 32'(sif.src_addr), 32'd2);
    step(10'd101, 10'd50, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000, "mt bil x101");
    check("mt bil x101 addr", 32'(sif.src_addr), 32'd8051);

    // Reset pulse mid-frame: outputs zero, mode falls back to nearest.
    step(10'd300, 10'd200, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000, "rst pre0");
    step(10'd301, 10'd200, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000, "rst pre1");
    step(10'd302, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, "rst a0");
    step(10'd302, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, "rst a1");
    step(10'd302, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, "rst a2");
    step(10'd303, 10'd200, 1'b1, 1'b0, 1'b1, 1'b1, 12'h470, "rst x303");
    check("rst x303 addr", 32'(sif.src_addr), 32'd32151);
    step(10'd304, 10'd200, 1'b1, 1'b0, 1'b1, 1'b1, 12'h480, "rst x304");
    check("rst x304 addr", 32'(sif.src_addr), 32'd32152);
    step(10'd305, 10'd200, 1'b1, 1'b0, 1'b1, 1'b1, 12'h480, "rst x305");
    idle(10'd200, 1'b1);
    check("blank src_en", 32'(sif.src_en), 32'd0);
    check("blank src_addr", 32'(sif.src_addr), 32'd0);
    idle(10'd200, 1'b1);
    idle(10'd200, 1'b1);
    idle(10'd200, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/interp_upscaler.md
INTERP_UPSCALER -- requirements
Module: interp_upscaler

Interface
REQ-001 Parameter SRC_W, default 320, source frame width in pixels.
REQ-002 Parameter SRC_H, default 240, source frame height in lines.
REQ-003 Parameter CH_W, default 4, bits per colour channel.
REQ-004 Parameter NCH, default 3, channel count; pixel width PW = NCH*CH_W, channel 0 in LSBs.
REQ-005 Parameter ADDR_W, default 17, source address width.
REQ-006 clk  input  1  pixel clock (25 MHz); reset  input  1  asynchronous, active-high.
REQ-007 x_pixel  input  10  destination column from VGA timing; y_pixel  input  10  destination line.
REQ-008 mode  input  1  0 = nearest-neighbour, 1 = bilinear; sampled per frame.
REQ-009 src_en  output  1  source read strobe; src_addr  output  ADDR_W  source read address.
REQ-010 src_data  input  PW  source pixel, valid exactly one clk after the src_addr it answers.
REQ-011 pix_out  output  PW  upscaled pixel; de_out  output  1  pix_out is active video.

Function
REQ-012 Active region SHALL be x_pixel < 2*SRC_W and y_pixel < 2*SRC_H; outside it src_en = 0, src_addr = 0.
REQ-013 Latency SHALL be 2 clk: pix_out/de_out at cycle t+2 correspond to x_pixel/y_pixel at cycle t; src_addr/src_en combinational from x_pixel/y_pixel.
REQ-014 Active mode SHALL be latched from mode when x_pixel = 0 and y_pixel = 0; mode changes mid-frame take effect next frame.
REQ-015 Nearest: col = x>>1, row = y>>1, src_addr = row*SRC_W + col, pix_out = src_data registered.
REQ-016 Bilinear fetch: col = min((x+1)>>1, SRC_W-1), row = min((y+1)>>1, SRC_H-1), src_addr = row*SRC_W + col.
REQ-017 Horizontal stage H: even x -> H = src_data; odd x -> H = avg(prev, src_data), prev = src_data of the preceding clk.
REQ-018 avg SHALL be per channel, (a + b + 1) >> 1 at CH_W+1 bits, truncated to CH_W (round half up, no overflow).
REQ-019 Even y: pix_out = H and line buffer entry [x] <= H; odd y: pix_out = avg(linebuf[x], H), no write.
REQ-020 Line buffer SHALL hold 2*SRC_W entries of PW bits, one write and one read per clk, same address.
REQ-021 Right edge: x = 2*SRC_W-1 clamps col, giving H = S[SRC_W-1] exactly; bottom edge: y = 2*SRC_H-1 clamps row, giving output = row SRC_H-1 values.
REQ-022 Outside active region pix_out = 0 and de_out = 0 (after 2-clk latency); line buffer not written.
REQ-023 prev SHALL NOT carry across lines; at x = 0 H = src_data regardless of prev.

Reset
REQ-024 On reset: pix_out = 0, de_out = 0, pipeline registers = 0, latched mode = 0 (nearest).
REQ-025 Line buffer contents SHALL NOT be reset; undefined until next even line rewrites them.
REQ-026 Reset mid-frame: outputs 0 while asserted; first valid de_out 2 clk after release in active region; mode stays 0 until next frame origin.

Structure
REQ-027 Shared package SHALL hold the MODE_NEAREST/MODE_BILINEAR constants and the channel-average function.
REQ-028 Line buffer SHALL be a separate sub-module interp_linebuf (single-port-per-side RAM, depth/width parameters, inferable as BRAM).
REQ-029 Address multiply SHALL be by constant SRC_W; no runtime divider.

Verification
REQ-030 Nearest, ramp source S[r][c] = {r[3:0], c[3:0], 4'h0}; dest (x=5,y=7) -> pix_out = S[3][2] two clk later.
REQ-031 Bilinear horizontal, y=0, S[0][0]=12'h000, S[0][1]=12'hFFF; x=1 -> pix_out = 12'h888 (round up).
REQ-032 Bilinear vertical, S[0][0]=12'h222, S[1][0]=12'h445; y=1, x=0 -> pix_out = 12'h334.
REQ-033 Edges: x=639 -> src_addr col 319 and pix_out = S[r][319]; y=479 -> row 239 only.
REQ-034 mode toggled 0->1 at x=100,y=50 -> nearest until frame end; bilinear from next (0,0).
REQ-035 reset pulsed at x=300,y=200 -> pix_out = 0, de_out = 0 during and 2 clk after; blanking (x=700) -> de_out = 0, src_en = 0.
